seg_scan_capture: RTL and testbench
===================================

# seg_scan_capture

Receive-side companion to the 3-digit multiplexed 7-segment counter display. It watches the scanned segment and digit-select lines and rebuilds the displayed 3-digit BCD value and its binary equivalent. It reports each complete frame with a one-cycle strobe and keeps sticky error flags. Used as an on-chip loopback monitor for the display path and as a self-check in board bring-up.

## Interface
- SETTLE, default 4: number of consecutive equal synchronized comparisons required before a select/segment pair is sampled; legal range 1..255.
- CLK  in  1  single system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- SEG_C  in  7  segment pattern, gfe_dcba, active-high; asynchronous to CLK.
- SEG_SEL  in  8  digit select, active-low one-hot; bit0 = ones, bit1 = tens, bit2 = hundreds; asynchronous.
- CLR_ERR  in  1  synchronous clear of ERR_FLAGS.
- DIG_1, DIG_10, DIG_100  out  4 each  last published BCD digits.
- BIN_VALUE  out  10  DIG_100*100 + DIG_10*10 + DIG_1, range 0..999.
- VALID  out  1  one-cycle pulse when a new frame is published.
- CHANGED  out  1  one-cycle pulse, coincident with VALID, when the published value differs from the previously held value.
- ERR_FLAGS  out  3  sticky flags: bit0 segment-pattern error, bit1 select error, bit2 sequence error.

## Operation
- **Synchronizer.** Two-flop synchronizer on SEG_C and SEG_SEL. Reset loads SEG_SEL stages to 8'hFF and SEG_C stages to 0.
- **Stability counter.**
  - Compare the synchronized pair with its one-cycle-delayed copy.
  - Any difference clears the counter to 0. Otherwise it increments, saturating at SETTLE.
  - A sample event fires on the cycle the counter goes from SETTLE-1 to SETTLE. There is exactly one event per stable interval.
- **Select decode at a sample event.**
  - 8'hFE gives pos0, 8'hFD gives pos1, 8'hFB gives pos2.
  - 8'hFF (blank) is ignored: no event.
  - Any other value sets ERR_FLAGS[1] and aborts the frame.
- **Segment decode at a sample event.** Inverse of the team's SEG_DEC table:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7C→6, 07→7, 7F→8, 67→9.
  - Any other pattern sets ERR_FLAGS[0] and aborts the frame.
- **Frame FSM.** States HUNT, GOT0, GOT1.
  - HUNT: a pos0 sample stores the ones digit into the shadow register and moves to GOT0. pos1 or pos2 is ignored silently; no error in HUNT.
  - GOT0: pos0 overwrites the ones shadow and stays. pos1 stores tens and moves to GOT1. pos2 sets ERR_FLAGS[2] and goes to HUNT.
  - GOT1: pos1 overwrites tens and stays. pos2 stores hundreds, schedules publish, and goes to HUNT. pos0 sets ERR_FLAGS[2], stores ones, and goes to GOT0 (resynchronize on the new frame start).
  - Abort means: return to HUNT, shadow digits discarded, nothing published.
- **Publish.**
  - DIG_* load from the shadows.
  - BIN_VALUE is computed from the shadow digits with shift-add: d100*100 = (d<<6)+(d<<5)+(d<<2); d10*10 = (d<<3)+(d<<1). Zero-extended to 10 bits, no overflow possible.
  - VALID = 1. CHANGED = 1 iff the new {DIG_100, DIG_10, DIG_1} differs from the held one.
- **Error flags.**
  - Sticky until CLR_ERR = 1.
  - If CLR_ERR and a new error occur in the same cycle, the new error wins and the flag reads 1.
  - Multiple flags may set in the same cycle.

## Timing
- Reset (RESET = 0 at a rising edge):
  - DIG_* = 0, BIN_VALUE = 0, VALID = 0, CHANGED = 0, ERR_FLAGS = 0.
  - FSM = HUNT, stability counter = 0.
  - Reset mid-frame discards the shadows; the first publish after release requires a full pos0, pos1, pos2 sequence.
- Latency:
  - A pin change reaches the comparator 2 cycles later (synchronizer).
  - The sample event fires SETTLE cycles after the first cycle the new pair appears at the synchronizer output.
  - VALID, DIG_*, BIN_VALUE and CHANGED all update on the cycle after the pos2 sample event, together.
- Sample window: a select or segment value held on the pins for fewer than SETTLE+1 cycles is never sampled.
- A glitch shorter than SETTLE cycles that returns to the prior value restarts the counter. If the prior value is then held long enough, a second sample of the same position occurs; that sample overwrites the shadow and raises no error.
- VALID never asserts two consecutive cycles; the minimum spacing between publishes is 3×(SETTLE+1) cycles.
- Values held by DIG_* and BIN_VALUE persist until the next publish or reset.

## Test plan
- **Reset and publish:** reset, then drive pos0/3F, pos1/06, pos2/5B, each held 10 cycles (SETTLE = 4) → VALID pulse once; DIG_100 = 2, DIG_10 = 1, DIG_1 = 0; BIN_VALUE = 210; CHANGED = 1; ERR_FLAGS = 0.
- **Repeat and change:** scan 999 (67 on all three) twice, then 000 → first frame VALID with CHANGED = 1 and BIN_VALUE = 999; second frame VALID with CHANGED = 0; third frame CHANGED = 1 and BIN_VALUE = 0.
- **Bad pattern:** pos0/3F, pos1/7B, pos2/06 → ERR_FLAGS = 3'b001, no VALID, DIG_* unchanged. Pulsing CLR_ERR afterwards gives ERR_FLAGS = 0.
- **Bad select and order:**
  - SEG_SEL = 8'hFC held 10 cycles → ERR_FLAGS[1] = 1.
  - Separately, pos0 then pos2 → ERR_FLAGS[2] = 1, no VALID.
- **Glitch filtering:** during a pos1 hold, drive SEG_C = 00 for 3 cycles, then return to 06 → no error; the frame publishes tens = 1.
- **Reset mid-frame:** assert RESET after the pos1 sample, release, then drive pos2/4F → no VALID until a full new pos0, pos1, pos2 frame arrives; all outputs read 0 after reset.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Loopback monitor for a 3-digit multiplexed 7-segment display: filters the scanned
// select/segment lines, rebuilds the shown BCD value and its binary form, and flags errors.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_HUNT | waiting for a ones-position sample to start a frame
// ST_GOT0 | ones digit captured, expecting tens
// ST_GOT1 | ones and tens captured, expecting hundreds
module seg_scan_capture #(
    parameter int SETTLE = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [6:0] seg_c_i,
    input  logic [7:0] seg_sel_i,
    input  logic       clr_err_i,
    output logic [3:0] dig_1_o,
    output logic [3:0] dig_10_o,
    output logic [3:0] dig_100_o,
    output logic [9:0] bin_value_o,
    output logic       valid_o,
    output logic       changed_o,
    output logic [2:0] err_flags_o
);

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_GOT0 = 2'd1,
        ST_GOT1 = 2'd2
    } state_t;

    logic [6:0] seg_s1_q, seg_s2_q, seg_dl_q;
    logic [7:0] sel_s1_q, sel_s2_q, sel_dl_q;
    logic [7:0] cnt_q, cnt_d;
    state_t     state_q, state_d;
    logic [3:0] sh_1_q, sh_1_d;
    logic [3:0] sh_10_q, sh_10_d;
    logic [3:0] dig_1_q, dig_1_d;
    logic [3:0] dig_10_q, dig_10_d;
    logic [3:0] dig_100_q, dig_100_d;
    logic [9:0] bin_q, bin_d;
    logic       valid_q, valid_d;
    logic       changed_q, changed_d;
    logic [2:0] err_q, err_d;

    logic       pair_diff;
    logic       sample;
    logic       pos0, pos1, pos2;
    logic       sel_blank, sel_bad;
    logic [3:0] seg_digit;
    logic       seg_ok;
    logic       ev_ok;
    logic       sel_err_new, seg_err_new, abort;
    logic       ld_1, ld_10, publish, seq_err;
    logic [9:0] x1, x10, x100;

    // Sampling pipeline: two sync stages plus a delayed copy for the stability compare.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            seg_dl_q <= '0;
            sel_s1_q <= 8'hFF;
            sel_s2_q <= 8'hFF;
            sel_dl_q <= 8'hFF;
            cnt_q    <= '0;
        end else begin
            seg_s1_q <= seg_c_i;
            seg_s2_q <= seg_s1_q;
            seg_dl_q <= seg_s2_q;
            sel_s1_q <= seg_sel_i;
            sel_s2_q <= sel_s1_q;
            sel_dl_q <= sel_s2_q;
            cnt_q    <= cnt_d;
        end
    end

    assign pair_diff = (seg_s2_q != seg_dl_q) || (sel_s2_q != sel_dl_q);

    always_comb begin
        cnt_d = cnt_q;
        if (pair_diff) begin
            cnt_d = '0;
        end else if (cnt_q != SETTLE_C) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // One event per stable interval: only the SETTLE-1 -> SETTLE step fires.
    assign sample = !pair_diff && (cnt_q == SETTLE_M1);

    always_comb begin
        pos0      = 1'b0;
        pos1      = 1'b0;
        pos2      = 1'b0;
        sel_blank = 1'b0;
        sel_bad   = 1'b0;
        case (sel_s2_q)
            8'hFE:   pos0      = 1'b1;
            8'hFD:   pos1      = 1'b1;
            8'hFB:   pos2      = 1'b1;
            8'hFF:   sel_blank = 1'b1;
            default: sel_bad   = 1'b1;
        endcase
    end

    always_comb begin
        seg_digit = 4'd0;
        seg_ok    = 1'b1;
        case (seg_s2_q)
            7'h3F:   seg_digit = 4'd0;
            7'h06:   seg_digit = 4'd1;
            7'h5B:   seg_digit = 4'd2;
            7'h4F:   seg_digit = 4'd3;
            7'h66:   seg_digit = 4'd4;
            7'h6D:   seg_digit = 4'd5;
            7'h7C:   seg_digit = 4'd6;
            7'h07:   seg_digit = 4'd7;
            7'h7F:   seg_digit = 4'd8;
            7'h67:   seg_digit = 4'd9;
            default: seg_ok    = 1'b0;
        endcase
    end

    // A blank select hides the segment lines entirely, so no segment check then.
    assign sel_err_new = sample && sel_bad;
    assign seg_err_new = sample && !sel_blank && !seg_ok;
    assign abort       = sel_err_new || seg_err_new;
    assign ev_ok       = sample && !sel_blank && !sel_bad && seg_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_HUNT;
        end else if (ev_ok) begin
            case (state_q)
                ST_HUNT: if (pos0) state_d = ST_GOT0;
                ST_GOT0: begin
                    if (pos1) state_d = ST_GOT1;
                    else if (pos2) state_d = ST_HUNT;
                end
                ST_GOT1: begin
                    if (pos2) state_d = ST_HUNT;
                    else if (pos0) state_d = ST_GOT0;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        ld_1    = 1'b0;
        ld_10   = 1'b0;
        publish = 1'b0;
        seq_err = 1'b0;
        if (ev_ok) begin
            case (state_q)
                ST_HUNT: ld_1 = pos0;
                ST_GOT0: begin
                    ld_1    = pos0;
                    ld_10   = pos1;
                    seq_err = pos2;
                end
                ST_GOT1: begin
                    ld_1    = pos0;
                    ld_10   = pos1;
                    publish = pos2;
                    seq_err = pos0;
                end
                default: ;
            endcase
        end
    end

    // Hundreds go straight from the decoder into the published digits.
    assign x1   = {6'd0, sh_1_q};
    assign x10  = ({6'd0, sh_10_q} << 3) + ({6'd0, sh_10_q} << 1);
    assign x100 = ({6'd0, seg_digit} << 6) + ({6'd0, seg_digit} << 5) + ({6'd0, seg_digit} << 2);

    always_comb begin
        sh_1_d    = ld_1 ? seg_digit : sh_1_q;
        sh_10_d   = ld_10 ? seg_digit : sh_10_q;
        dig_1_d   = dig_1_q;
        dig_10_d  = dig_10_q;
        dig_100_d = dig_100_q;
        bin_d     = bin_q;
        valid_d   = publish;
        changed_d = 1'b0;
        if (publish) begin
            dig_1_d   = sh_1_q;
            dig_10_d  = sh_10_q;
            dig_100_d = seg_digit;
            bin_d     = x100 + x10 + x1;
            changed_d = {seg_digit, sh_10_q, sh_1_q} != {dig_100_q, dig_10_q, dig_1_q};
        end
        err_d = (clr_err_i ? 3'b000 : err_q) | {seq_err, sel_err_new, seg_err_new};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sh_1_q    <= '0;
            sh_10_q   <= '0;
            dig_1_q   <= '0;
            dig_10_q  <= '0;
            dig_100_q <= '0;
            bin_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= '0;
        end else begin
            sh_1_q    <= sh_1_d;
            sh_10_q   <= sh_10_d;
            dig_1_q   <= dig_1_d;
            dig_10_q  <= dig_10_d;
            dig_100_q <= dig_100_d;
            bin_q     <= bin_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            err_q     <= err_d;
        end
    end

    assign dig_1_o     = dig_1_q;
    assign dig_10_o    = dig_10_q;
    assign dig_100_o   = dig_100_q;
    assign bin_value_o = bin_q;
    assign valid_o     = valid_q;
    assign changed_o   = changed_q;
    assign err_flags_o = err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: pin-level model of the scan/settle/frame rules checked every
// cycle, plus literal expectations after each directed scenario.
module tb_seg_scan_capture;

    localparam int SETTLE = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_c;
    logic [7:0] seg_sel;
    logic       clr_err;
    logic [3:0] dig_1, dig_10, dig_100;
    logic [9:0] bin_value;
    logic       valid, changed;
    logic [2:0] err_flags;

    seg_scan_capture #(.SETTLE(SETTLE)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .seg_c_i    (seg_c),
        .seg_sel_i  (seg_sel),
        .clr_err_i  (clr_err),
        .dig_1_o    (dig_1),
        .dig_10_o   (dig_10),
        .dig_100_o  (dig_100),
        .bin_value_o(bin_value),
        .valid_o    (valid),
        .changed_o  (changed),
        .err_flags_o(err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [14:0] p1, p2, prev;
    int          run;
    int          st;
    int          d[3];
    int          m_d1, m_d10, m_d100, m_bin;
    logic        m_valid, m_chg;
    logic [2:0]  m_err;
    logic        armed = 1'b0;

    // Literal expectation handshake
    int lit_d1, lit_d10, lit_d100, lit_bin, lit_err, lit_nv, lit_nc;
    int req_id = 0;
    int ack_id = 0;
    int n_valid_seen = 0;
    int n_chg_seen   = 0;

    function automatic int seg2dig(input logic [6:0] s);
        case (s)
            7'h3F: return 0;
            7'h06: return 1;
            7'h5B: return 2;
            7'h4F: return 3;
            7'h66: return 4;
            7'h6D: return 5;
            7'h7C: return 6;
            7'h07: return 7;
            7'h7F: return 8;
            7'h67: return 9;
            default: return -1;
        endcase
    endfunction

    // -1 = blank, -2 = illegal select
    function automatic int sel2pos(input logic [7:0] s);
        case (s)
            8'hFE: return 0;
            8'hFD: return 1;
            8'hFB: return 2;
            8'hFF: return -1;
            default: return -2;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [14:0] x;
        logic [2:0]  new_err;
        int          pos, dg;
        if (!rst_n) begin
            p1 = {8'hFF, 7'h00};
            p2 = p1;
            prev = p1;
            run = 1;
            st = 0;
            d[0] = 0; d[1] = 0; d[2] = 0;
            m_d1 = 0; m_d10 = 0; m_d100 = 0; m_bin = 0;
            m_valid = 1'b0; m_chg = 1'b0; m_err = 3'b000;
            armed = 1'b1;
        end else begin
            x = p2;
            p2 = p1;
            p1 = {seg_sel, seg_c};
            if (x == prev) begin
                if (run < 1000) run++;
            end else begin
                run = 1;
            end
            prev = x;
            m_valid = 1'b0;
            m_chg = 1'b0;
            new_err = 3'b000;
            if (run == SETTLE + 1) begin
                pos = sel2pos(x[14:7]);
                dg  = seg2dig(x[6:0]);
                if (pos != -1) begin
                    if (pos == -2) new_err[1] = 1'b1;
                    if (dg < 0) new_err[0] = 1'b1;
                    if (new_err != 3'b000) begin
                        st = 0;
                    end else if (st == 0) begin
                        if (pos == 0) begin d[0] = dg; st = 1; end
                    end else if (st == 1) begin
                        if (pos == 0) d[0] = dg;
                        else if (pos == 1) begin d[1] = dg; st = 2; end
                        else begin new_err[2] = 1'b1; st = 0; end
                    end else begin
                        if (pos == 1) d[1] = dg;
                        else if (pos == 0) begin new_err[2] = 1'b1; d[0] = dg; st = 1; end
                        else begin
                            m_valid = 1'b1;
                            m_chg = (dg != m_d100) || (d[1] != m_d10) || (d[0] != m_d1);
                            m_d100 = dg; m_d10 = d[1]; m_d1 = d[0];
                            m_bin = dg * 100 + d[1] * 10 + d[0];
                            st = 0;
                        end
                    end
                end
            end
            m_err = (clr_err ? 3'b000 : m_err) | new_err;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("dig_1", int'(dig_1), m_d1);
            chk("dig_10", int'(dig_10), m_d10);
            chk("dig_100", int'(dig_100), m_d100);
            chk("bin_value", int'(bin_value), m_bin);
            chk("valid", int'(valid), int'(m_valid));
            chk("changed", int'(changed), int'(m_chg));
            chk("err_flags", int'(err_flags), int'(m_err));
            if (valid) n_valid_seen++;
            if (changed) n_chg_seen++;
        end
        if (req_id != ack_id) begin
            ack_id = req_id;
            chk("lit_dig_100", int'(dig_100), lit_d100);
            chk("lit_dig_10", int'(dig_10), lit_d10);
            chk("lit_dig_1", int'(dig_1), lit_d1);
            chk("lit_bin", int'(bin_value), lit_bin);
            chk("lit_model_bin", m_bin, lit_bin);
            chk("lit_err", int'(err_flags), lit_err);
            chk("lit_valid_count", n_valid_seen, lit_nv);
            chk("lit_changed_count", n_chg_seen, lit_nc);
        end
    end

    task automatic hold(input logic [7:0] sel, input logic [6:0] seg, input int n);
        seg_sel = sel;
        seg_c = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] s1, input logic [6:0] s10, input logic [6:0] s100);
        hold(8'hFE, s1, 10);
        hold(8'hFD, s10, 10);
        hold(8'hFB, s100, 10);
    endtask

    task automatic expect_lit(input int e100, input int e10, input int e1, input int eb,
                              input int ee, input int env, input int enc);
        lit_d100 = e100; lit_d10 = e10; lit_d1 = e1; lit_bin = eb;
        lit_err = ee; lit_nv = env; lit_nc = enc;
        req_id++;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        seg_sel = 8'hFF;
        seg_c = 7'h00;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        expect_lit(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // 210
        frame(7'h3F, 7'h06, 7'h5B);
        hold(8'hFF, 7'h00, 10);
        expect_lit(2, 1, 0, 210, 0, 1, 1);

        // 999 twice then 000
        frame(7'h67, 7'h67, 7'h67);
        hold(8'hFF, 7'h00, 4);
        expect_lit(9, 9, 9, 999, 0, 2, 2);
        frame(7'h67, 7'h67, 7'h67);
        hold(8'hFF, 7'h00, 4);
        expect_lit(9, 9, 9, 999, 0, 3, 2);
        frame(7'h3F, 7'h3F, 7'h3F);
        hold(8'hFF, 7'h00, 4);
        expect_lit(0, 0, 0, 0, 0, 4, 3);

        // Bad segment pattern in tens aborts the frame
        frame(7'h3F, 7'h7B, 7'h06);
        hold(8'hFF, 7'h00, 4);
        expect_lit(0, 0, 0, 0, 1, 4, 3);
        pulse_clr();
        expect_lit(0, 0, 0, 0, 0, 4, 3);

        // Illegal select
        hold(8'hFC, 7'h3F, 10);
        expect_lit(0, 0, 0, 0, 2, 4, 3);
        pulse_clr();

        // pos0 then pos2: sequence error
        hold(8'hFE, 7'h3F, 10);
        hold(8'hFB, 7'h06, 10);
        expect_lit(0, 0, 0, 0, 4, 4, 3);
        pulse_clr();
        expect_lit(0, 0, 0, 0, 0, 4, 3);

        // Short segment glitch during tens hold, then resample of tens
        hold(8'hFE, 7'h66, 10);
        hold(8'hFD, 7'h06, 10);
        hold(8'hFD, 7'h00, 3);
        hold(8'hFD, 7'h06, 10);
        hold(8'hFB, 7'h4F, 10);
        hold(8'hFF, 7'h00, 4);
        expect_lit(3, 1, 4, 314, 0, 5, 4);

        // Reset after the tens sample
        hold(8'hFE, 7'h07, 10);
        hold(8'hFD, 7'h7F, 10);
        rst_n = 1'b0;
        @(negedge clk);
        expect_lit(0, 0, 0, 0, 0, 5, 4);
        rst_n = 1'b1;
        hold(8'hFD, 7'h7F, 10);
        hold(8'hFB, 7'h4F, 10);
        hold(8'hFF, 7'h00, 10);
        expect_lit(0, 0, 0, 0, 0, 5, 4);
        frame(7'h06, 7'h5B, 7'h4F);
        hold(8'hFF, 7'h00, 4);
        expect_lit(3, 2, 1, 321, 0, 6, 5);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
